// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time from instruction memory
// and holds it for decode. Handles branch redirects and flushes with a kill flag.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  op,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_ir;
  logic              r_kill;

  logic [XLEN-1:0]   w_flush_pc;
  logic [XLEN-1:0]   w_branch_pc;
  logic [XLEN-1:0]   w_pc_inc;
  logic              w_unused;

  // Low address bits of redirect targets are forced to word alignment.
  assign w_flush_pc  = {flush_pc[XLEN-1:2], 2'b00};
  assign w_branch_pc = {branch_target[XLEN-1:2], 2'b00};
  assign w_pc_inc    = r_pc + XLEN'(4);
  assign w_unused    = ^{flush_pc[1:0], branch_target[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_kill  <= 1'b0;
    end else if (flush) begin
      // Flush wins: restart at flush_pc; an already-issued request is marked for discard.
      r_pc <= w_flush_pc;
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) begin
            r_state <= S_WAIT;
            r_kill  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_state <= S_REQ;
            r_kill  <= 1'b0;
          end else begin
            r_kill  <= 1'b1;
          end
        end
        S_HOLD: r_state <= S_REQ;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_ir    <= imem_rsp_data;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            r_pc    <= branch_taken ? w_branch_pc : w_pc_inc;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign instr_valid    = (r_state == S_HOLD);
  assign instr          = r_ir;
  assign pc             = r_pc;
  assign op             = r_ir[OPW-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a rule-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  op;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc            (pc),
    .op            (op),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: what the fetch stage is doing, as independent flags.
  bit          e_started;
  bit          e_req;
  bit          e_outst;
  bit          e_kill;
  bit          e_held;
  logic [31:0] e_pc;
  logic [31:0] e_ir;
  bit          use_sb;

  int          mem_cnt;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h00A0_0093;
      32'h0000_0008: return 32'h0000_0063;
      default:       return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_started = 0;
    e_req     = 0;
    e_outst   = 0;
    e_kill    = 0;
    e_held    = 0;
    e_pc      = RST_PC;
    e_ir      = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_update();
    logic [31:0] fal, tal;
    bit got, acc, ret, take;
    bit n_req, n_outst, n_kill, n_held;
    fal   = {flush_pc[31:2], 2'b00};
    tal   = {branch_target[31:2], 2'b00};
    got   = e_outst && imem_rsp_valid;
    acc   = e_req && imem_req_ready;
    ret   = e_held && instr_ready && !flush;
    take  = got && !e_kill && !flush;
    n_req   = !e_started || (got && (e_kill || flush)) || ret
              || (e_held && flush) || (e_req && !imem_req_ready);
    n_outst = acc || (e_outst && !imem_rsp_valid);
    n_kill  = (acc && flush) || (e_outst && !imem_rsp_valid && (e_kill || flush));
    n_held  = take || (e_held && !instr_ready && !flush);
    if (take) e_ir = imem_rsp_data;
    if (flush)    e_pc = fal;
    else if (ret) e_pc = branch_taken ? tal : e_pc + 32'd4;
    e_started = 1;
    e_req     = n_req;
    e_outst   = n_outst;
    e_kill    = n_kill;
    e_held    = n_held;
  endtask

  task automatic check_outputs();
    chk("req_valid",   {31'd0, imem_req_valid}, {31'd0, e_req});
    chk("req_addr",    imem_req_addr, e_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_held});
    chk("instr",       instr, e_ir);
    chk("pc",          pc, e_pc);
    chk("op",          {25'd0, op}, {25'd0, e_ir[6:0]});
    if (use_sb && e_held) chk("held_word", instr, mem_word(e_pc));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_in(input bit rdy, input bit rv, input logic [31:0] rd, input bit ir,
                        input bit bt, input logic [31:0] tg, input bit fl, input logic [31:0] fp);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    instr_ready    = ir;
    branch_taken   = bt;
    branch_target  = tg;
    flush          = fl;
    flush_pc       = fp;
  endtask

  // Memory responder: one response per accepted request after 1..lat_max cycles.
  task automatic mem_drive(input int ready_pct, input int lat_max);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
      end
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    if (e_req && imem_req_ready) begin
      mem_cnt  = int'($urandom_range(lat_max, 1));
      mem_addr = e_pc;
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    use_sb  = 0;
    mem_cnt = 0;
    mem_addr = '0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Zero-wait fetch of 0,4,8 then a branch from pc=8 to 0x103 -> 0x100.
    for (int c = 0; c < 10; c++) begin
      set_in(0, 0, 0, 1, (c == 9), 32'h0000_0103, 0, 0);
      mem_drive(100, 1);
      step();
      case (c + 1)
        1: chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        3: begin
          chk("seq0_pc", pc, 32'h0);
          chk("seq0_op", {25'd0, op}, 32'h13);
        end
        6: begin
          chk("seq1_pc", pc, 32'h4);
          chk("seq1_op", {25'd0, op}, 32'h13);
        end
        9: begin
          chk("seq2_pc", pc, 32'h8);
          chk("seq2_op", {25'd0, op}, 32'h63);
        end
        10: chk("branch_addr", imem_req_addr, 32'h0000_0100);
        default: ;
      endcase
    end

    // Flush while waiting; stale word arrives afterwards and must be dropped.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);             step();
    set_in(0, 0, 0, 0, 0, 0, 1, 32'h0000_0201); step();
    chk("flush_wait_addr", imem_req_addr, 32'h0000_0200);
    set_in(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0); step();
    chk("stale_dropped_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_dropped_instr", instr, 32'h0000_0063);
    chk("flush_req_addr", imem_req_addr, 32'h0000_0200);
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      mem_drive(100, 1);
      step();
    end
    chk("flush_fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("flush_fetch_instr", instr, mem_word(32'h0000_0200));

    // Flush coinciding with the response.
    set_in(0, 0, 0, 1, 0, 0, 0, 0);             step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);             step();
    set_in(0, 1, 32'hCAFE_0001, 0, 0, 0, 1, 32'h0000_0300); step();
    chk("flush_rsp_addr", imem_req_addr, 32'h0000_0300);
    chk("flush_rsp_valid", {31'd0, instr_valid}, 32'd0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);             step();
    set_in(0, 1, 32'h0000_00B3, 0, 0, 0, 0, 0); step();
    chk("after_flush_rsp_instr", instr, 32'h0000_00B3);
    chk("after_flush_rsp_op", {25'd0, op}, 32'h33);

    // Flush in REQ with ready: first response discarded, re-request at flush_pc.
    set_in(0, 0, 0, 1, 0, 0, 0, 0);             step();
    set_in(1, 0, 0, 0, 0, 0, 1, 32'h0000_0400); step();
    chk("flush_req_wait_rv", {31'd0, imem_req_valid}, 32'd0);
    set_in(0, 1, 32'h1111_1111, 0, 0, 0, 0, 0); step();
    chk("killed_rsp_valid", {31'd0, instr_valid}, 32'd0);
    chk("rereq_addr", imem_req_addr, 32'h0000_0400);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);             step();
    set_in(0, 1, 32'h0000_0023, 0, 0, 0, 0, 0); step();
    chk("rereq_instr", instr, 32'h0000_0023);
    chk("rereq_pc", pc, 32'h0000_0400);

    // PC wrap at the top of the address space.
    set_in(0, 0, 0, 1, 1, 32'hFFFF_FFFE, 0, 0); step();
    chk("top_addr", imem_req_addr, 32'hFFFF_FFFC);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);             step();
    set_in(0, 1, 32'h0000_006F, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 0, 0, 0, 0);             step();
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Asynchronous reset while waiting; late response after release is ignored.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);             step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("async_rst_instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 1, 32'hBADB_AD00, 0, 0, 0, 0, 0); step();
    chk("post_rst_req_addr", imem_req_addr, RST_PC);
    chk("post_rst_instr", instr, 32'h0);

    // Randomized traffic with variable memory latency, branches, flushes and strays.
    use_sb  = 1;
    mem_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      set_in(0, 0, 0, ($urandom_range(3) != 0), ($urandom_range(3) == 0), $urandom,
             ($urandom_range(15) == 0), $urandom);
      mem_drive(70, 3);
      if (mem_cnt == 0 && !e_outst && !imem_rsp_valid && $urandom_range(19) == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that owns the program counter, requests instruction words from instruction memory over a valid/ready request and valid response interface, and holds the fetched word for the decode/execute stage. It sits directly upstream of the main decoder: its `op` output drives the decoder's opcode input. It also accepts branch redirects and asynchronous-to-pipeline flushes. At most one memory request is outstanding at any time.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `imem_req_valid` out, 1: fetch request valid.
- `imem_req_addr` out, 32: fetch byte address, always word-aligned.
- `imem_req_ready` in, 1: memory accepts the request this cycle.
- `imem_rsp_valid` in, 1: response word valid, one cycle pulse per accepted request.
- `imem_rsp_data` in, 32: instruction word.
- `instr_valid` out, 1: `instr`/`pc`/`op` hold a valid instruction.
- `instr` out, 32: held instruction word.
- `pc` out, 32: address of the held instruction.
- `op` out, 7: `instr[6:0]`, to the main decoder.
- `instr_ready` in, 1: downstream retires the held instruction this cycle.
- `branch_taken` in, 1: retiring instruction redirects control flow.
- `branch_target` in, 32: redirect target; bits [1:0] are ignored and treated as 00.
- `flush` in, 1: discard all fetch state and restart at `flush_pc`.
- `flush_pc` in, 32: restart address; bits [1:0] are treated as 00.

## Operation
- Registers:
  - `pc_q`, 32 bits.
  - `ir_q`, 32 bits.
  - `kill_q`, 1 bit: the outstanding response is to be discarded.
  - State.
- `imem_req_addr = pc_q`. `pc = pc_q`. `instr = ir_q`. `op = ir_q[6:0]`.
- States:
  - IDLE: entered only from reset. Next cycle goes to REQ unconditionally. `imem_req_valid=0`.
  - REQ: `imem_req_valid=1`. When `imem_req_ready=1`, go to WAIT.
  - WAIT: `imem_req_valid=0`. When `imem_rsp_valid=1`:
    - If `kill_q=1`: drop the word, clear `kill_q`, go to REQ.
    - Otherwise: `ir_q<=imem_rsp_data`, go to HOLD.
  - HOLD: `instr_valid=1`. When `instr_ready=1`:
    - `pc_q <= branch_taken ? {branch_target[31:2],2'b00} : pc_q+4`, with 32-bit wrap (FFFF_FFFC+4 = 0).
    - Go to REQ.
- `branch_taken` is sampled only in HOLD with `instr_ready=1`; it is ignored in all other cycles.
- `flush` has priority over everything else. In every state, it loads `pc_q <= {flush_pc[31:2],2'b00}`, and then:
  - IDLE: go to REQ.
  - REQ, with `imem_req_ready=0`: stay in REQ. The address changes while valid; this is legal only under flush.
  - REQ, with `imem_req_ready=1`: the request at the old address is accepted. Go to WAIT and set `kill_q=1`.
  - WAIT, with `imem_rsp_valid=0`: set `kill_q=1` and stay in WAIT.
  - WAIT, with `imem_rsp_valid=1`: drop the word, `kill_q<=0`, go to REQ.
  - HOLD: drop the instruction (`instr_valid` falls next cycle), go to REQ. `instr_ready`/`branch_taken` are ignored.
- `instr_valid` is 1 only in HOLD. `imem_req_valid` is 1 only in REQ.
- Responses arriving outside WAIT are a protocol error. They are ignored and must not change any state.

## Timing
- Reset values:
  - `pc_q=RESET_PC`, `ir_q=0`, `kill_q=0`, state IDLE.
  - Therefore `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `instr_valid=0`, `instr=0`, `op=0`, `pc=RESET_PC`.
- Reset assertion mid-operation clears everything immediately and asynchronously. Any outstanding response after release is ignored because the state is not WAIT.
- First request: `imem_req_valid` rises in the first cycle after the first clock edge following `rst_n` release.
- Latency from request acceptance at edge N:
  - The response may arrive at edge N+1 or later.
  - `instr_valid` is high from the cycle after the response edge.
- Zero-wait-state memory gives 3 cycles per instruction: REQ, WAIT, HOLD. `instr_ready` must be high in HOLD.
- All outputs are functions of registered state only; there are no combinational input-to-output paths.

## Test plan
- Reset release, memory always ready, 1-cycle response returning 0x00000013, 0x00A00093, 0x0000_0063, `instr_ready=1` -> `pc` shows 0, 4, 8; `op` shows 0x13, 0x13, 0x63; 3-cycle cadence.
- HOLD at pc=8 with `instr_ready=1`, `branch_taken=1`, `branch_target=0x103` -> next `imem_req_addr=0x100`.
- Request accepted, `flush=1` with `flush_pc=0x200` in WAIT, stale response 0xDEADBEEF two cycles later -> word dropped, `instr_valid` stays 0, next request at 0x200, next held instruction comes from 0x200.
- `flush` in the same cycle as `imem_rsp_valid` -> word dropped, REQ at `flush_pc` next cycle, `kill_q=0`.
- `flush` in REQ coinciding with `imem_req_ready=1` -> WAIT with kill set; the first response is discarded; a second request at `flush_pc`.
- `pc_q=0xFFFFFFFC` retired without branch -> next request at 0x00000000. `rst_n` asserted in WAIT, then a response arrives after release -> ignored, fetch restarts at `RESET_PC`.
